call_return_sequencer: RTL and testbench

//   Acts on the subroutine-control decode from the instruction register. Owns the

---
 rtl/call_return_sequencer_if.sv | 29 ++
 rtl/call_return_sequencer.sv | 113 +++++++++++
 tb/tb_call_return_sequencer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/call_return_sequencer_if.sv
// Decode-side bus of the call/return sequencer: subroutine decode inputs in,
// fetch address, flush and stack status out.
interface call_return_sequencer_if #(
  parameter int PC_W  = 10,
  parameter int DEPTH = 8
);
  localparam int SP_W = $clog2(DEPTH) + 1;

  logic            hold;
  logic            bsr_det;
  logic            ret_det;
  logic [9:0]      relative_jump;
  logic [PC_W-1:0] pc;
  logic            flush;
  logic [SP_W-1:0] sp;
  logic            stack_overflow;
  logic            stack_underflow;
  logic            fault;

  modport master (
    output hold, bsr_det, ret_det, relative_jump,
    input  pc, flush, sp, stack_overflow, stack_underflow, fault
  );

  modport slave (
    input  hold, bsr_det, ret_det, relative_jump,
    output pc, flush, sp, stack_overflow, stack_underflow, fault
  );
endinterface

// File: rtl/call_return_sequencer.sv
// Program counter plus hardware return-address stack driven by BSR/RET decode.
// Taken jumps insert one flush cycle; stack misuse traps into a sticky FAULT state.
module call_return_sequencer #(
  parameter int PC_W     = 10,
  parameter int DEPTH    = 8,
  parameter int RESET_PC = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  call_return_sequencer_if.slave bus
);
  localparam int SP_W  = $clog2(DEPTH) + 1;
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {RUN, FLUSH, FAULT} state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [SP_W-1:0] sp_q, sp_d;
  logic            flush_q, flush_d;
  logic            fault_q, fault_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;

  logic [PC_W-1:0]  stack_mem [DEPTH];
  logic             push_en;
  logic [IDX_W-1:0] push_idx;
  logic [IDX_W-1:0] pop_idx;
  logic [PC_W-1:0]  offset;

  // Offset is sign-extended (or truncated) to the PC width; the add wraps naturally.
  assign offset   = PC_W'($signed(bus.relative_jump));
  assign push_idx = sp_q[IDX_W-1:0];
  assign pop_idx  = IDX_W'(sp_q - SP_W'(1));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    sp_d    = sp_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push_en = 1'b0;
    if (!bus.hold) begin
      case (state_q)
        RUN: begin
          if (bus.ret_det) begin
            if (sp_q != '0) begin
              pc_d    = stack_mem[pop_idx];
              sp_d    = sp_q - SP_W'(1);
              state_d = FLUSH;
            end else begin
              unf_d   = 1'b1;
              state_d = FAULT;
            end
          end else if (bus.bsr_det) begin
            if (sp_q != SP_W'(DEPTH)) begin
              push_en = 1'b1;
              pc_d    = pc_q + offset;
              sp_d    = sp_q + SP_W'(1);
              state_d = FLUSH;
            end else begin
              ovf_d   = 1'b1;
              state_d = FAULT;
            end
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
        FLUSH: begin
          pc_d    = pc_q + PC_W'(1);
          state_d = RUN;
        end
        default: ;
      endcase
    end
    // Outputs follow the next state so they are registered alongside it.
    flush_d = (state_d == FLUSH);
    fault_d = (state_d == FAULT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= PC_W'(RESET_PC);
      sp_q    <= '0;
      flush_q <= 1'b0;
      fault_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      flush_q <= flush_d;
      fault_q <= fault_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push_en) begin
      stack_mem[push_idx] <= pc_q;
    end
  end

  assign bus.pc              = pc_q;
  assign bus.sp              = sp_q;
  assign bus.flush           = flush_q;
  assign bus.fault           = fault_q;
  assign bus.stack_overflow  = ovf_q;
  assign bus.stack_underflow = unf_q;
endmodule

// File: tb/tb_call_return_sequencer.sv
// Directed and randomized checks of call_return_sequencer against a queue-based
// model of the return stack and program counter.
module tb_call_return_sequencer;
  localparam int PC_W     = 10;
  localparam int DEPTH    = 8;
  localparam int RESET_PC = 0;
  localparam int PC_MOD   = 1 << PC_W;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   failures = 0;

  // Reference state: PC as an integer, return addresses in a queue.
  int  m_pc;
  int  ret_q[$];
  bit  m_flush, m_fault, m_ovf, m_unf;

  call_return_sequencer_if #(.PC_W(PC_W), .DEPTH(DEPTH)) bus ();

  call_return_sequencer #(.PC_W(PC_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit rst, input bit h, input bit b, input bit r, input logic [9:0] off);
    int s;
    if (!rst) begin
      m_pc = RESET_PC;
      ret_q.delete();
      m_flush = 0; m_fault = 0; m_ovf = 0; m_unf = 0;
    end else if (h || m_fault) begin
    end else if (m_flush) begin
      m_pc = (m_pc + 1) % PC_MOD;
      m_flush = 0;
    end else if (r) begin
      if (ret_q.size() > 0) begin
        m_pc = ret_q.pop_back();
        m_flush = 1;
      end else begin
        m_unf = 1; m_fault = 1;
      end
    end else if (b) begin
      if (ret_q.size() < DEPTH) begin
        ret_q.push_back(m_pc);
        s = off[9] ? int'(off) - 1024 : int'(off);
        m_pc = (m_pc + s + 4 * PC_MOD) % PC_MOD;
        m_flush = 1;
      end else begin
        m_ovf = 1; m_fault = 1;
      end
    end else begin
      m_pc = (m_pc + 1) % PC_MOD;
    end
  endtask

  task automatic check_output();
    check_val("pc",        32'(bus.pc),              32'(m_pc));
    check_val("sp",        32'(bus.sp),              32'(ret_q.size()));
    check_val("flush",     32'(bus.flush),           32'(m_flush));
    check_val("fault",     32'(bus.fault),           32'(m_fault));
    check_val("overflow",  32'(bus.stack_overflow),  32'(m_ovf));
    check_val("underflow", 32'(bus.stack_underflow), 32'(m_unf));
  endtask

  task automatic apply_stimulus(input bit rst, input bit h, input bit b, input bit r, input logic [9:0] off);
    @(negedge clk);
    rst_n             = rst;
    bus.hold          = h;
    bus.bsr_det       = b;
    bus.ret_det       = r;
    bus.relative_jump = off;
    @(posedge clk);
    model_step(rst, h, b, r, off);
    #1;
    check_output();
  endtask

  task automatic plain(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1, 0, 0, 0, 10'($urandom));
  endtask

  initial begin
    rst_n = 1'b0;
    bus.hold = 1'b0; bus.bsr_det = 1'b0; bus.ret_det = 1'b0; bus.relative_jump = '0;

    // Reset overrides hold and decode inputs; then free-running pc 1..5.
    apply_stimulus(0, 1, 1, 1, 10'h155);
    check_val("reset_pc", 32'(bus.pc), 32'(RESET_PC));
    for (int i = 1; i <= 5; i++) begin
      apply_stimulus(1, 0, 0, 0, 10'h0);
      check_val("plain_pc", 32'(bus.pc), 32'(i));
    end

    // BSR +0x20 at pc 0x010, RET three cycles later.
    plain(16 - 5 - 1);
    check_val("pre_bsr_pc", 32'(bus.pc), 32'h00F);
    plain(1);
    apply_stimulus(1, 0, 1, 0, 10'h020);
    check_val("bsr_target", 32'(bus.pc), 32'h030);
    check_val("bsr_flush", 32'(bus.flush), 32'd1);
    plain(2);
    apply_stimulus(1, 0, 0, 1, 10'h0);
    check_val("ret_target", 32'(bus.pc), 32'h010);
    check_val("ret_sp", 32'(bus.sp), 32'd0);
    plain(1);
    check_val("ret_after_flush", 32'(bus.pc), 32'h011);

    // Negative offset wraps below zero; return address must be 0x005.
    apply_stimulus(0, 0, 0, 0, 10'h0);
    plain(5);
    apply_stimulus(1, 0, 1, 0, 10'h3F0);
    check_val("wrap_target", 32'(bus.pc), 32'h3F5);
    plain(1);
    apply_stimulus(1, 0, 0, 1, 10'h0);
    check_val("wrap_return", 32'(bus.pc), 32'h005);

    // Fill the stack, then one more BSR traps into overflow and freezes.
    apply_stimulus(0, 0, 0, 0, 10'h0);
    for (int i = 0; i < DEPTH; i++) begin
      apply_stimulus(1, 0, 1, 0, 10'($urandom));
      plain(1);
    end
    apply_stimulus(1, 0, 1, 0, 10'h004);
    check_val("ovf_sp", 32'(bus.sp), 32'(DEPTH));
    check_val("ovf_flag", 32'(bus.stack_overflow), 32'd1);
    for (int i = 0; i < 4; i++) apply_stimulus(1, 0, i[0], i[1], 10'($urandom));
    apply_stimulus(0, 0, 0, 0, 10'h0);
    check_val("ovf_cleared", 32'(bus.fault), 32'd0);

    // RET on an empty stack traps into underflow; later BSR is ignored.
    apply_stimulus(1, 0, 0, 1, 10'h0);
    check_val("unf_flag", 32'(bus.stack_underflow), 32'd1);
    apply_stimulus(1, 0, 1, 0, 10'h010);
    check_val("unf_frozen_pc", 32'(bus.pc), 32'(RESET_PC));

    // BSR+RET together with sp=1 pops; hold during FLUSH stretches the flush.
    apply_stimulus(0, 0, 0, 0, 10'h0);
    apply_stimulus(1, 0, 1, 0, 10'h040);
    plain(1);
    apply_stimulus(1, 0, 1, 1, 10'h100);
    check_val("both_pop_pc", 32'(bus.pc), 32'(RESET_PC));
    check_val("both_pop_sp", 32'(bus.sp), 32'd0);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1, 1, 1, 0, 10'h0);
      check_val("hold_flush", 32'(bus.flush), 32'd1);
    end
    plain(1);
    check_val("hold_release", 32'(bus.flush), 32'd0);

    // Randomized mix of resets, holds, calls and returns.
    for (int i = 0; i < 2000; i++) begin
      apply_stimulus($urandom_range(39) != 0, $urandom_range(7) == 0,
                     $urandom_range(3) == 0, $urandom_range(5) == 0, 10'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end
endmodule
